mem_wait_responder: RTL

- Memory-side responder for the multi-cycle CPU's control FSM.
- It accepts word read/write requests (instruction fetch or data access) and models a memory with a configurable number of wait states. It returns data together with a one-cycle ack.
- It lets the CPU controller stall its IF/MEM states on ack instead of assuming single-cycle memory.
- It sits between the CPU datapath's memory port and the word RAM.

---
 rtl/mem_wait_responder_pkg.sv | 13 +
 rtl/mem_wait_responder_if.sv | 25 ++
 rtl/mem_wait_responder_ram.sv | 31 +++
 rtl/mem_wait_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_wait_responder_pkg.sv
// rtl/mem_wait_responder_pkg.sv - shared types and constants for the wait-state memory responder
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int CNT_W  = 4;
  localparam int NBYTES = 4;

endpackage

// File: rtl/mem_wait_responder_if.sv
// rtl/mem_wait_responder_if.sv - CPU memory-port bundle between requester and responder
interface mem_wait_responder_if;
  import mem_resp_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [NBYTES-1:0] be;
  logic              ack;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err, busy
  );

endinterface

// File: rtl/mem_wait_responder_ram.sv
// rtl/mem_wait_responder_ram.sv - single-port word RAM, byte write enables, write-first read
module mem_word_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     idx,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Disabled lanes return the stored byte, so a write yields the merged word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (we && be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          rdata[8*i +: 8]    <= wdata[8*i +: 8];
        end else begin
          rdata[8*i +: 8]    <= mem[idx][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - memory responder with configurable wait states and one-cycle ack
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_wait_responder_if.slave  mem_if
);

  localparam int              CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(CNT_INIT_I);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]       be_q, be_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;

  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_idx;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [NBYTES-1:0]       ram_be;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  logic                    addr_bad;
  logic [DATA_WIDTH-1:0]   resp_data;

  assign addr_bad  = (mem_if.addr[1:0] != 2'b00) || (mem_if.addr[31:ADDR_WIDTH+2] != '0);
  assign resp_data = err_q ? '0 : ram_rdata;

  mem_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = err_q;
    hold_d    = hold_q;
    ram_en    = 1'b0;
    ram_we    = we_q;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    ram_be    = be_q;

    case (state_q)
      IDLE: begin
        if (mem_if.req) begin
          we_d    = mem_if.we;
          idx_d   = mem_if.addr[ADDR_WIDTH+1:2];
          wdata_d = mem_if.wdata;
          be_d    = mem_if.be;
          err_d   = addr_bad;
          if (addr_bad) begin
            state_d = RESP;
          end else if (LATENCY == 0) begin
            // Zero wait states: access straight from the live request.
            ram_en    = 1'b1;
            ram_we    = mem_if.we;
            ram_idx   = mem_if.addr[ADDR_WIDTH+1:2];
            ram_wdata = mem_if.wdata;
            ram_be    = mem_if.be;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ram_en  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        hold_d  = resp_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_if.ack   = (state_q == RESP);
  assign mem_if.err   = (state_q == RESP) && err_q;
  assign mem_if.busy  = (state_q != IDLE);
  assign mem_if.rdata = (state_q == RESP) ? resp_data : hold_q;

endmodule
